// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and widths for the sequence responder: the
//               responder state encoding, the cycle-counter width and the
//               statistics-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Width of every run/delay/drive counter; wide enough for 16 without wrap.
    localparam int c_cnt_w   = 5;
    // Width of the optional statistics counters.
    localparam int c_stats_w = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_cnt.sv
`default_nettype none
// ============================================================================
// Module      : seq_cnt
// Description : Small cycle counter with synchronous load, saturating
//               decrement (never wraps below zero) and a zero flag.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset, clears the count
//               load     - load load_val (takes priority over dec)
//               load_val - value to load
//               dec      - decrement by one, holds at zero
//               cnt      - current count
//               zero     - high when cnt is zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_cnt
    import seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [c_cnt_w-1:0] load_val,
    input  logic               dec,
    output logic [c_cnt_w-1:0] cnt,
    output logic               zero
);

    localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign cnt  = r_cnt;
    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/seq_responder.sv
`default_nettype none
// ============================================================================
// Module      : seq_responder
// Description : Watches trig for ANT_LEN consecutive high samples while idle
//               (a match), then after DELAY edges drives ce high for CONS_LEN
//               consecutive sampled cycles. trig is ignored while a response
//               is pending or being driven.
// Parameters  : ANT_LEN  (1..16) consecutive high trig samples for a match
//               CONS_LEN (1..16) cycles ce is sampled high per response
//               DELAY    (1..16) edges from match to first ce-high sample
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               trig - antecedent input
//               ce   - registered response output
//               busy - registered, high while in WAIT or DRIVE
//               match_cnt, drop_cnt - saturating statistics (optional)
// Options     : SEQ_RESPONDER_STATS_EN adds match_cnt / drop_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_responder
    import seq_pkg::*;
#(
    parameter int ANT_LEN  = 2,
    parameter int CONS_LEN = 2,
    parameter int DELAY    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig,
    output logic                 ce,
    output logic                 busy
`ifdef SEQ_RESPONDER_STATS_EN
    ,
    output logic [c_stats_w-1:0] match_cnt,
    output logic [c_stats_w-1:0] drop_cnt
`endif
);

    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_ant_last  = c_cnt_w'(ANT_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cons_last = c_cnt_w'(CONS_LEN - 1);
    // The match edge itself is the first of DELAY edges and the edge that
    // enters DRIVE is the last, so WAIT holds for DELAY-2 further edges.
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'((DELAY > 1) ? (DELAY - 2) : 0);
    localparam bit                 c_direct    = (DELAY == 1);

    seq_state_t r_state;
    logic       r_ce;
    logic       r_busy;

    logic [c_cnt_w-1:0] w_run_cnt;
    logic [c_cnt_w-1:0] w_run_next;
    logic [c_cnt_w-1:0] w_dly_cnt;
    logic [c_cnt_w-1:0] w_drv_cnt;
    logic               w_run_zero;
    logic               w_dly_zero;
    logic               w_drv_zero;
    logic               w_at_thresh;
    logic               w_match;
    logic               w_drv_load;
    logic               w_unused;

    assign w_at_thresh = (w_run_cnt == c_ant_last);
    assign w_match     = (r_state == IDLE) && trig && w_at_thresh;

    // The run counter reloads every edge: it grows on high trig in IDLE and
    // is cleared on a low sample, on a match and whenever not idle.
    assign w_run_next  = ((r_state == IDLE) && trig && !w_match) ? (w_run_cnt + c_one) : '0;

    assign w_drv_load  = (w_match && c_direct) || ((r_state == WAIT) && w_dly_zero);

    seq_cnt u_run (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b1),
        .load_val (w_run_next),
        .dec      (1'b0),
        .cnt      (w_run_cnt),
        .zero     (w_run_zero)
    );

    seq_cnt u_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (w_match),
        .load_val (c_wait_load),
        .dec      (r_state == WAIT),
        .cnt      (w_dly_cnt),
        .zero     (w_dly_zero)
    );

    seq_cnt u_drv (
        .clk      (clk),
        .rst      (rst),
        .load     (w_drv_load),
        .load_val (c_cons_last),
        .dec      (r_state == DRIVE),
        .cnt      (w_drv_cnt),
        .zero     (w_drv_zero)
    );

    // Counter values that only feed the zero flags.
    assign w_unused = ^{w_run_zero, w_dly_cnt, w_drv_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ce    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_match) begin
                        r_busy <= 1'b1;
                        if (c_direct) begin
                            r_state <= DRIVE;
                            r_ce    <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_dly_zero) begin
                        r_state <= DRIVE;
                        r_ce    <= 1'b1;
                    end
                end
                DRIVE: begin
                    // Leave on the edge where ce is sampled high for the last time.
                    if (w_drv_zero) begin
                        r_state <= IDLE;
                        r_ce    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ce    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ce   = r_ce;
    assign busy = r_busy;

`ifdef SEQ_RESPONDER_STATS_EN
    localparam logic [c_stats_w-1:0] c_stats_one = c_stats_w'(1);

    logic [c_stats_w-1:0] r_match_cnt;
    logic [c_stats_w-1:0] r_drop_cnt;
    logic                 w_drop;

    assign w_drop = (r_state != IDLE) && trig && w_at_thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_match && (r_match_cnt != '1)) begin
                r_match_cnt <= r_match_cnt + c_stats_one;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + c_stats_one;
            end
        end
    end

    assign match_cnt = r_match_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_responder
// Description : Directed bench for seq_responder. Instance a uses the default
//               parameters (DELAY=1), instance b uses DELAY=3; both share
//               clk, rst and trig. Edge k of a scenario is the k-th rising
//               edge after the scenario starts; the value checked at the
//               falling edge before edge k is the value sampled at edge k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trig = 1'b0;
    logic ce_a, busy_a, ce_b, busy_b;
`ifdef SEQ_RESPONDER_STATS_EN
    logic [15:0] mc_a, dc_a, mc_b, dc_b;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int n_match_a   = 0;
    int n_match_b   = 0;

    always #5 clk = ~clk;

    seq_responder #(.ANT_LEN(2), .CONS_LEN(2), .DELAY(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .ce        (ce_a),
        .busy      (busy_a)
`ifdef SEQ_RESPONDER_STATS_EN
        ,
        .match_cnt (mc_a),
        .drop_cnt  (dc_a)
`endif
    );

    seq_responder #(.ANT_LEN(2), .CONS_LEN(2), .DELAY(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .ce        (ce_b),
        .busy      (busy_b)
`ifdef SEQ_RESPONDER_STATS_EN
        ,
        .match_cnt (mc_b),
        .drop_cnt  (dc_b)
`endif
    );

    // ------------------------------------------------------------------
    // Port-level match model: with ANT_LEN=2 a match is two consecutive
    // edges sampling trig high while busy is low. hist_x[i] means a match
    // occurred i+1 edges ago; history is cleared by reset.
    // ------------------------------------------------------------------
    logic       hit_a, hit_b, m_a, m_b;
    logic [2:0] hist_a;
    logic [4:0] hist_b;

    assign m_a = hit_a && !busy_a && trig;
    assign m_b = hit_b && !busy_b && trig;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_a  <= 1'b0;
            hit_b  <= 1'b0;
            hist_a <= '0;
            hist_b <= '0;
        end else begin
            hit_a  <= !busy_a && trig;
            hit_b  <= !busy_b && trig;
            hist_a <= {hist_a[1:0], m_a};
            hist_b <= {hist_b[3:0], m_b};
            if (m_a) n_match_a <= n_match_a + 1;
            if (m_b) n_match_b <= n_match_b + 1;
        end
    end

    // DELAY=1: ce high at t+1, t+2, low at t+3.
    a_a1: assert property (@(posedge clk) disable iff (rst) hist_a[0] |-> ce_a)
        else begin $display("FAIL assert_a_t1 ce_a=%b want 1", ce_a); miscompares++; end
    a_a2: assert property (@(posedge clk) disable iff (rst) hist_a[1] |-> ce_a)
        else begin $display("FAIL assert_a_t2 ce_a=%b want 1", ce_a); miscompares++; end
    a_a3: assert property (@(posedge clk) disable iff (rst) hist_a[2] |-> !ce_a)
        else begin $display("FAIL assert_a_t3 ce_a=%b want 0", ce_a); miscompares++; end
    // DELAY=3: ce low at t+1, t+2, high at t+3, t+4, low at t+5.
    a_b1: assert property (@(posedge clk) disable iff (rst) hist_b[0] |-> !ce_b)
        else begin $display("FAIL assert_b_t1 ce_b=%b want 0", ce_b); miscompares++; end
    a_b2: assert property (@(posedge clk) disable iff (rst) hist_b[1] |-> !ce_b)
        else begin $display("FAIL assert_b_t2 ce_b=%b want 0", ce_b); miscompares++; end
    a_b3: assert property (@(posedge clk) disable iff (rst) hist_b[2] |-> ce_b)
        else begin $display("FAIL assert_b_t3 ce_b=%b want 1", ce_b); miscompares++; end
    a_b4: assert property (@(posedge clk) disable iff (rst) hist_b[3] |-> ce_b)
        else begin $display("FAIL assert_b_t4 ce_b=%b want 1", ce_b); miscompares++; end
    a_b5: assert property (@(posedge clk) disable iff (rst) hist_b[4] |-> !ce_b)
        else begin $display("FAIL assert_b_t5 ce_b=%b want 0", ce_b); miscompares++; end

    c_match_a: cover property (@(posedge clk) disable iff (rst) m_a);
    c_match_b: cover property (@(posedge clk) disable iff (rst) m_b);

    // ------------------------------------------------------------------
    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({ce_a, busy_a, ce_b, busy_b} !== 4'b0000) begin
            $display("FAIL reset_async got ce_a=%b busy_a=%b ce_b=%b busy_b=%b want all 0",
                     ce_a, busy_a, ce_b, busy_b);
            miscompares++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ce_a, busy_a, ce_b, busy_b} !== 4'b0000) begin
            $display("FAIL reset_release got ce_a=%b busy_a=%b ce_b=%b busy_b=%b want all 0",
                     ce_a, busy_a, ce_b, busy_b);
            miscompares++;
        end
    endtask

    // trig high at edges 1,2 only.
    task automatic test_delay();
        logic [7:0] tv    = 8'h03;
        logic [7:0] ce_av = 8'h0C;
        logic [7:0] bz_av = 8'h0C;
        logic [7:0] ce_bv = 8'h30;
        logic [7:0] bz_bv = 8'h3C;
        trig = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if ({ce_a, busy_a} !== {ce_av[k-1], bz_av[k-1]}) begin
                $display("FAIL delay1 edge %0d got ce=%b busy=%b want ce=%b busy=%b",
                         k, ce_a, busy_a, ce_av[k-1], bz_av[k-1]);
                miscompares++;
            end
            vectors++;
            if ({ce_b, busy_b} !== {ce_bv[k-1], bz_bv[k-1]}) begin
                $display("FAIL delay3 edge %0d got ce=%b busy=%b want ce=%b busy=%b",
                         k, ce_b, busy_b, ce_bv[k-1], bz_bv[k-1]);
                miscompares++;
            end
            trig = tv[k-1];
        end
        trig = 1'b0;
    endtask

    // trig high at edges 1 and 3 only: never two consecutive samples.
    task automatic test_no_match();
        logic [5:0] tv = 6'b000101;
        trig = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if ({ce_a, busy_a, ce_b, busy_b} !== 4'b0000) begin
                $display("FAIL no_match edge %0d got ce_a=%b busy_a=%b ce_b=%b busy_b=%b want all 0",
                         k, ce_a, busy_a, ce_b, busy_b);
                miscompares++;
            end
            trig = tv[k-1];
        end
        trig = 1'b0;
    endtask

    // trig held high edges 1..8.
    task automatic test_continuous();
        logic [13:0] tv    = 14'h00FF;
        logic [13:0] ce_av = 14'h00CC;
        logic [13:0] bz_av = 14'h00CC;
        logic [13:0] ce_bv = 14'h0C30;
        logic [13:0] bz_bv = 14'h0F3C;
        trig = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            vectors++;
            if ({ce_a, busy_a} !== {ce_av[k-1], bz_av[k-1]}) begin
                $display("FAIL cont_a edge %0d got ce=%b busy=%b want ce=%b busy=%b",
                         k, ce_a, busy_a, ce_av[k-1], bz_av[k-1]);
                miscompares++;
            end
            vectors++;
            if ({ce_b, busy_b} !== {ce_bv[k-1], bz_bv[k-1]}) begin
                $display("FAIL cont_b edge %0d got ce=%b busy=%b want ce=%b busy=%b",
                         k, ce_b, busy_b, ce_bv[k-1], bz_bv[k-1]);
                miscompares++;
            end
`ifdef SEQ_RESPONDER_STATS_EN
            if (k == 9) begin
                vectors++;
                if (mc_a !== 16'd2 || dc_a !== 16'd0) begin
                    $display("FAIL stats_a got match_cnt=%0d drop_cnt=%0d want 2 0", mc_a, dc_a);
                    miscompares++;
                end
            end
`endif
            trig = tv[k-1];
        end
        trig = 1'b0;
    endtask

    // trig high edges 1,2; reset pulse between edges 3 and 4.
    task automatic test_reset_abort();
        logic [2:0] tv    = 3'b011;
        logic [2:0] ce_av = 3'b100;
        logic [2:0] bz_av = 3'b100;
        logic [2:0] ce_bv = 3'b000;
        logic [2:0] bz_bv = 3'b100;
        trig = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({ce_a, busy_a, ce_b, busy_b} !== {ce_av[k-1], bz_av[k-1], ce_bv[k-1], bz_bv[k-1]}) begin
                $display("FAIL abort_pre edge %0d got %b%b%b%b want %b%b%b%b", k,
                         ce_a, busy_a, ce_b, busy_b, ce_av[k-1], bz_av[k-1], ce_bv[k-1], bz_bv[k-1]);
                miscompares++;
            end
            trig = tv[k-1];
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({ce_a, busy_a, ce_b, busy_b} !== 4'b0000) begin
            $display("FAIL abort_in_rst got ce_a=%b busy_a=%b ce_b=%b busy_b=%b want all 0",
                     ce_a, busy_a, ce_b, busy_b);
            miscompares++;
        end
        #1 rst = 1'b0;
        for (int k = 4; k <= 9; k++) begin
            @(negedge clk);
            vectors++;
            if ({ce_a, busy_a, ce_b, busy_b} !== 4'b0000) begin
                $display("FAIL abort_post edge %0d got ce_a=%b busy_a=%b ce_b=%b busy_b=%b want all 0",
                         k, ce_a, busy_a, ce_b, busy_b);
                miscompares++;
            end
        end
    endtask

    // trig high during reset, then one more high sample after release.
    task automatic test_reset_trig();
        trig = 1'b0;
        repeat (4) @(negedge clk);
        rst  = 1'b1;
        trig = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        trig = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if ({ce_a, busy_a, ce_b, busy_b} !== 4'b0000) begin
                $display("FAIL rst_trig edge %0d got ce_a=%b busy_a=%b ce_b=%b busy_b=%b want all 0",
                         k, ce_a, busy_a, ce_b, busy_b);
                miscompares++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_match();
        test_continuous();
        test_delay();
        test_reset_abort();
        test_reset_trig();
        repeat (2) @(negedge clk);
        vectors++;
        if (n_match_a == 0) begin
            $display("FAIL vacuity_a match antecedent count=%0d want >0", n_match_a);
            miscompares++;
        end
        vectors++;
        if (n_match_b == 0) begin
            $display("FAIL vacuity_b match antecedent count=%0d want >0", n_match_b);
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
